// File: rtl/ezusb_fifo_slave_if.sv
// Slave-FIFO pin strobes/flags plus the host-side IN/OUT word streams.
interface ezusb_fifo_slave_if;
  logic        SLWR;
  logic        SLRD;
  logic        SLOE;
  logic [1:0]  FIFOADDR;
  logic        PKTEND;
  logic        EMPTY_FLAG;
  logic        FULL_FLAG;
  logic [15:0] HOST_DI;
  logic        HOST_DI_valid;
  logic        HOST_DI_ready;
  logic [15:0] HOST_DO;
  logic        HOST_DO_last;
  logic        HOST_DO_zlp;
  logic        HOST_DO_valid;
  logic        HOST_DO_ready;
  logic [15:0] overflow_cnt;
  logic [15:0] underflow_cnt;

  modport slave (
    input  SLWR, SLRD, SLOE, FIFOADDR, PKTEND, HOST_DI, HOST_DI_valid, HOST_DO_ready,
    output EMPTY_FLAG, FULL_FLAG, HOST_DI_ready, HOST_DO, HOST_DO_last, HOST_DO_zlp,
           HOST_DO_valid, overflow_cnt, underflow_cnt
  );

  modport master (
    output SLWR, SLRD, SLOE, FIFOADDR, PKTEND, HOST_DI, HOST_DI_valid, HOST_DO_ready,
    input  EMPTY_FLAG, FULL_FLAG, HOST_DI_ready, HOST_DO, HOST_DO_last, HOST_DO_zlp,
           HOST_DO_valid, overflow_cnt, underflow_cnt
  );
endinterface

// File: rtl/ezusb_fifo_slave.sv
// EZ-USB side of the Slave FIFO interface: OUT packet assembly, IN FWFT read-out, delayed flags.
// Optional EZUSB_FIFO_STALL_EN: LFSR-driven random forced-full windows on the OUT path.
module ezusb_fifo_slave #(
  parameter int OUTEP        = 2,
  parameter int INEP         = 6,
  parameter int OUT_DEPTH    = 1024,
  parameter int IN_DEPTH     = 1024,
  parameter int PKT_WORDS    = 256,
  parameter int FLAG_LATENCY = 2
) (
  input  logic              ifclk,
  input  logic              reset,
  inout  wire  [15:0]       fd,
  ezusb_fifo_slave_if.slave bus
);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam int IAW = $clog2(IN_DEPTH);
  localparam int PCW = $clog2(PKT_WORDS + 1);
  localparam logic [1:0] OUT_SEL = 2'((OUTEP / 2 - 1) & 3);
  localparam logic [1:0] IN_SEL  = 2'((INEP / 2 - 1) & 3);

  logic [17:0]  r_out_mem [OUT_DEPTH];
  logic [OAW-1:0] r_out_wp, r_out_rp;
  logic [OAW:0]   r_out_cnt;
  logic           r_stg_vld;
  logic [15:0]    r_stg_data;
  logic [PCW-1:0] r_pkt_cnt;
  logic           r_pktend_d;

  logic [15:0]    r_in_mem [IN_DEPTH];
  logic [IAW-1:0] r_in_wp, r_in_rp;
  logic [IAW:0]   r_in_cnt;

  logic [15:0] r_ovf, r_unf;
  logic [FLAG_LATENCY-1:0] r_ne_dly, r_nf_dly;

  logic           w_stall;
  logic [OAW:0]   w_out_tot;
  logic           w_out_room, w_wr_req, w_wr, w_pe, w_auto, w_pop;
  logic [PCW-1:0] w_pkt_next;
  logic [1:0]     w_push;
  logic           w_we;
  logic [OAW-1:0] w_waddr;
  logic [17:0]    w_wdata;
  logic [17:0]    w_head;
  logic           w_in_push, w_rd_req, w_in_pop, w_fd_oe;
  logic [15:0]    w_fd_out;

`ifdef EZUSB_FIFO_STALL_EN
  logic [15:0] r_lfsr;
  logic [3:0]  r_stall_cnt;

  always_ff @(posedge ifclk) begin
    if (reset) begin
      r_lfsr      <= 16'hACE1;
      r_stall_cnt <= 4'd0;
    end else begin
      r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
      if (r_stall_cnt != 4'd0)
        r_stall_cnt <= r_stall_cnt - 4'd1;
      else if (r_lfsr[15:12] == 4'hF)
        r_stall_cnt <= {1'b0, r_lfsr[2:0]} + 4'd1;
    end
  end
  assign w_stall = (r_stall_cnt != 4'd0);
`else
  assign w_stall = 1'b0;
`endif

  // The staged word already sits in RAM at r_out_wp; committing only advances the pointer
  // (or rewrites that entry with last=1), so every cycle needs at most one RAM write.
  assign w_out_tot  = r_out_cnt + {{OAW{1'b0}}, r_stg_vld};
  assign w_out_room = (w_out_tot != (OAW+1)'(OUT_DEPTH)) && !w_stall;
  assign w_wr_req   = !bus.SLWR && bus.SLOE && (bus.FIFOADDR == OUT_SEL);
  assign w_wr       = w_wr_req && w_out_room;
  assign w_pe       = !bus.PKTEND && r_pktend_d && (bus.FIFOADDR == OUT_SEL) && w_out_room;
  assign w_pkt_next = r_pkt_cnt + PCW'(1);
  assign w_auto     = w_wr && (w_pkt_next == PCW'(PKT_WORDS));
  assign w_pop      = (r_out_cnt != '0) && bus.HOST_DO_ready;

  always_comb begin
    w_push  = 2'd0;
    w_we    = 1'b0;
    w_waddr = r_out_wp;
    w_wdata = 18'h0;
    if (w_wr) begin
      w_we    = 1'b1;
      w_waddr = r_out_wp + OAW'(r_stg_vld);
      if (w_auto || w_pe) begin
        w_wdata = {2'b01, fd};
        w_push  = {1'b0, r_stg_vld} + 2'd1;
      end else begin
        w_wdata = {2'b00, fd};
        w_push  = {1'b0, r_stg_vld};
      end
    end else if (w_pe) begin
      w_we    = 1'b1;
      w_push  = 2'd1;
      w_wdata = r_stg_vld ? {2'b01, r_stg_data} : {2'b11, 16'h0000};
    end
  end

  always_ff @(posedge ifclk) begin
    if (w_we) r_out_mem[w_waddr] <= w_wdata;
    if (w_in_push) r_in_mem[r_in_wp] <= bus.HOST_DI;
  end

  assign w_in_push = bus.HOST_DI_valid && bus.HOST_DI_ready;
  assign w_rd_req  = !bus.SLRD && !bus.SLOE && (bus.FIFOADDR == IN_SEL);
  assign w_in_pop  = w_rd_req && (r_in_cnt != '0);

  always_ff @(posedge ifclk) begin
    if (reset) begin
      r_out_wp   <= '0;
      r_out_rp   <= '0;
      r_out_cnt  <= '0;
      r_stg_vld  <= 1'b0;
      r_stg_data <= 16'h0000;
      r_pkt_cnt  <= '0;
      r_pktend_d <= 1'b1;
      r_in_wp    <= '0;
      r_in_rp    <= '0;
      r_in_cnt   <= '0;
      r_ovf      <= 16'h0000;
      r_unf      <= 16'h0000;
      r_ne_dly   <= '0;
      r_nf_dly   <= '1;
    end else begin
      r_pktend_d <= bus.PKTEND;
      r_out_wp   <= r_out_wp + OAW'(w_push);
      r_out_rp   <= r_out_rp + OAW'(w_pop);
      r_out_cnt  <= r_out_cnt + (OAW+1)'(w_push) - (OAW+1)'(w_pop);
      if (w_wr && !(w_auto || w_pe)) begin
        r_stg_vld  <= 1'b1;
        r_stg_data <= fd;
        r_pkt_cnt  <= w_pkt_next;
      end else if (w_wr || w_pe) begin
        r_stg_vld <= 1'b0;
        r_pkt_cnt <= '0;
      end
      r_in_wp  <= r_in_wp + IAW'(w_in_push);
      r_in_rp  <= r_in_rp + IAW'(w_in_pop);
      r_in_cnt <= r_in_cnt + (IAW+1)'(w_in_push) - (IAW+1)'(w_in_pop);
      if (w_wr_req && !w_out_room && r_ovf != 16'hFFFF) r_ovf <= r_ovf + 16'd1;
      if (w_rd_req && r_in_cnt == '0 && r_unf != 16'hFFFF) r_unf <= r_unf + 16'd1;
      r_ne_dly[0] <= (r_in_cnt != '0);
      r_nf_dly[0] <= w_out_room;
      for (int i = 1; i < FLAG_LATENCY; i++) begin
        r_ne_dly[i] <= r_ne_dly[i-1];
        r_nf_dly[i] <= r_nf_dly[i-1];
      end
    end
  end

  assign w_head            = r_out_mem[r_out_rp];
  assign bus.HOST_DO       = w_head[15:0];
  assign bus.HOST_DO_last  = w_head[16];
  assign bus.HOST_DO_zlp   = w_head[17];
  assign bus.HOST_DO_valid = (r_out_cnt != '0);
  assign bus.HOST_DI_ready = !reset && (r_in_cnt != (IAW+1)'(IN_DEPTH));
  assign bus.EMPTY_FLAG    = r_ne_dly[FLAG_LATENCY-1];
  assign bus.FULL_FLAG     = r_nf_dly[FLAG_LATENCY-1];
  assign bus.overflow_cnt  = r_ovf;
  assign bus.underflow_cnt = r_unf;

  assign w_fd_oe  = !bus.SLOE && (bus.FIFOADDR == IN_SEL) && !reset;
  assign w_fd_out = (r_in_cnt != '0) ? r_in_mem[r_in_rp] : 16'h0000;
  assign fd       = w_fd_oe ? w_fd_out : 16'hzzzz;
endmodule

// File: tb/tb_ezusb_fifo_slave.sv
// Scoreboard bench for ezusb_fifo_slave: expected OUT beats queued at stimulus, checked by a monitor.
module tb_ezusb_fifo_slave;
  typedef struct packed {
    logic        zlp;
    logic        last;
    logic [15:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  wire  [15:0] fd;
  logic [15:0] tb_fd = 16'h0000;
  int   errors = 0;
  int   checks = 0;
  beat_t exp_q[$];

  ezusb_fifo_slave_if bus();
  ezusb_fifo_slave dut (.ifclk(clk), .reset(rst), .fd(fd), .bus(bus));

  assign fd = bus.SLOE ? tb_fd : 16'hzzzz;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.HOST_DO_valid && bus.HOST_DO_ready) begin
      beat_t e;
      beat_t a;
      a = {bus.HOST_DO_zlp, bus.HOST_DO_last, bus.HOST_DO};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL host_do_unexpected actual=%h required=none", a);
      end else begin
        e = exp_q.pop_front();
        if (e.zlp ? (a.zlp !== 1'b1 || a.last !== 1'b1) : (a !== e)) begin
          errors++;
          $display("FAIL host_do_beat actual=%h required=%h", a, e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_beat(input logic zlp, input logic last, input logic [15:0] d);
    beat_t b;
    b = {zlp, last, d};
    exp_q.push_back(b);
  endtask

  task automatic out_write(input logic [15:0] d, input logic pe);
    bus.SLWR = 1'b0; bus.SLOE = 1'b1; bus.FIFOADDR = 2'd0; tb_fd = d;
    bus.PKTEND = !pe;
    cyc();
    bus.SLWR = 1'b1; bus.PKTEND = 1'b1;
  endtask

  task automatic pktend(input int hold);
    bus.FIFOADDR = 2'd0; bus.PKTEND = 1'b0;
    repeat (hold) cyc();
    bus.PKTEND = 1'b1;
    cyc();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.HOST_DO_valid) && n < 3000) begin
      cyc();
      n++;
    end
    check(name, {31'd0, (exp_q.size() != 0 || bus.HOST_DO_valid)}, 32'd0);
  endtask

  initial begin
    logic [15:0] exp_rd [5];
    exp_rd = '{16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h0000};
    bus.SLWR = 1'b1; bus.SLRD = 1'b1; bus.SLOE = 1'b1; bus.FIFOADDR = 2'd0;
    bus.PKTEND = 1'b1; bus.HOST_DI = 16'h0; bus.HOST_DI_valid = 1'b0; bus.HOST_DO_ready = 1'b1;

    repeat (3) cyc();
    check("rst_empty_flag", {31'd0, bus.EMPTY_FLAG}, 32'd0);
    check("rst_full_flag", {31'd0, bus.FULL_FLAG}, 32'd1);
    check("rst_do_valid", {31'd0, bus.HOST_DO_valid}, 32'd0);
    check("rst_di_ready", {31'd0, bus.HOST_DI_ready}, 32'd0);
    check("rst_ovf", {16'd0, bus.overflow_cnt}, 32'd0);
    rst = 1'b0;
    cyc();
    check("post_rst_di_ready", {31'd0, bus.HOST_DI_ready}, 32'd1);

`ifndef EZUSB_FIFO_STALL_EN
    // Two auto-committed packets
    for (int i = 0; i < 512; i++) begin
      expect_beat(1'b0, (i % 256) == 255, 16'(i));
      out_write(16'(i), 1'b0);
    end
    drain("drain_512");
    check("ovf_after_512", {16'd0, bus.overflow_cnt}, 32'd0);

    // Short packet, ZLP, ignored strobes, held PKTEND, write+PKTEND same cycle
    expect_beat(1'b0, 1'b0, 16'h00A1); out_write(16'h00A1, 1'b0);
    expect_beat(1'b0, 1'b0, 16'h00A2); out_write(16'h00A2, 1'b0);
    expect_beat(1'b0, 1'b1, 16'h00A3); out_write(16'h00A3, 1'b0);
    pktend(1);
    expect_beat(1'b1, 1'b1, 16'h0000);
    pktend(1);
    bus.SLWR = 1'b0; bus.SLOE = 1'b1; bus.FIFOADDR = 2'd1; tb_fd = 16'hDEAD;
    cyc();
    bus.FIFOADDR = 2'd0; bus.SLOE = 1'b0;
    cyc();
    bus.SLWR = 1'b1; bus.SLOE = 1'b1;
    expect_beat(1'b1, 1'b1, 16'h0000);
    pktend(3);
    expect_beat(1'b0, 1'b0, 16'h00B1); out_write(16'h00B1, 1'b0);
    expect_beat(1'b0, 1'b1, 16'h00B2); out_write(16'h00B2, 1'b1);
    cyc();
    drain("drain_short");

    // Overflow with consumer stalled
    bus.HOST_DO_ready = 1'b0;
    for (int i = 0; i < 1030; i++) begin
      if (i < 1024) expect_beat(1'b0, (i % 256) == 255, 16'h2000 + 16'(i));
      out_write(16'h2000 + 16'(i), 1'b0);
      if (i == 1024) check("full_flag_lat1", {31'd0, bus.FULL_FLAG}, 32'd1);
      if (i == 1025) check("full_flag_lat2", {31'd0, bus.FULL_FLAG}, 32'd0);
    end
    check("ovf_1030", {16'd0, bus.overflow_cnt}, 32'd6);
    bus.HOST_DO_ready = 1'b1;
    drain("drain_full");
    repeat (3) cyc();
    check("full_flag_recover", {31'd0, bus.FULL_FLAG}, 32'd1);
`endif

    // IN path read-out
    bus.HOST_DI_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.HOST_DI = 16'h1000 + 16'(i);
      cyc();
    end
    bus.HOST_DI_valid = 1'b0;
    repeat (3) cyc();
    check("empty_flag_set", {31'd0, bus.EMPTY_FLAG}, 32'd1);
    bus.SLOE = 1'b0; bus.FIFOADDR = 2'd2; bus.SLRD = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check("fd_read", {16'd0, fd}, {16'd0, exp_rd[j]});
      cyc();
    end
    bus.SLRD = 1'b1;
    check("empty_flag_lat1", {31'd0, bus.EMPTY_FLAG}, 32'd1);
    cyc();
    check("empty_flag_lat2", {31'd0, bus.EMPTY_FLAG}, 32'd0);
    check("unf_cnt", {16'd0, bus.underflow_cnt}, 32'd1);
    bus.SLOE = 1'b1; bus.FIFOADDR = 2'd0;

`ifndef EZUSB_FIFO_STALL_EN
    // Reset mid-packet
    bus.HOST_DO_ready = 1'b0;
    for (int i = 0; i < 10; i++) out_write(16'h3000 + 16'(i), 1'b0);
    rst = 1'b1;
    cyc();
    check("midrst_di_ready", {31'd0, bus.HOST_DI_ready}, 32'd0);
    cyc();
    rst = 1'b0;
    cyc();
    check("midrst_do_valid", {31'd0, bus.HOST_DO_valid}, 32'd0);
    check("midrst_empty", {31'd0, bus.EMPTY_FLAG}, 32'd0);
    check("midrst_full", {31'd0, bus.FULL_FLAG}, 32'd1);
    check("midrst_ovf", {16'd0, bus.overflow_cnt}, 32'd0);
    check("midrst_unf", {16'd0, bus.underflow_cnt}, 32'd0);
    bus.HOST_DO_ready = 1'b1;
    expect_beat(1'b1, 1'b1, 16'h0000);
    pktend(1);
    drain("drain_midrst_zlp");
`else
    // Re-sending master through random stalls
    begin
      int w;
      int n;
      logic [15:0] prev;
      w = 0;
      n = 0;
      while (w < 4096 && n < 40000) begin
        prev = bus.overflow_cnt;
        out_write(16'(w), 1'b0);
        if (bus.overflow_cnt == prev) begin
          expect_beat(1'b0, (w % 256) == 255, 16'(w));
          w++;
        end
        n++;
      end
      check("stall_all_sent", w, 32'd4096);
      check("stall_ovf_nonzero", {31'd0, bus.overflow_cnt != 16'd0}, 32'd1);
      drain("drain_stall");
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
